// File: rtl/sdram_pkg.sv
// Shared types and widths for the sdram-port to MiSTer DDRAM responder.
//   - sdram_resp_state_t : responder FSM states
//   - SDRAM_AW/SDRAM_DW  : CPU-side port address/data widths (32-bit word addressed)
//   - DDRAM_AW/DDRAM_DW  : DDRAM Avalon-MM address/data widths (64-bit word addressed)
//   - half_be/pick_half  : byte-enable and read-data selection for one 32-bit half
package sdram_pkg;

    localparam int SDRAM_AW = 22;
    localparam int SDRAM_DW = 32;
    localparam int DDRAM_AW = 29;
    localparam int DDRAM_DW = 64;
    // One DDRAM line holds two port words, so the line tag drops address bit 0.
    localparam int TAG_W    = SDRAM_AW - 1;

    typedef enum logic [2:0] {
        IDLE,
        WR_CMD,
        WR_ACK,
        RD_CMD,
        RD_WAIT,
        RD_ACK
    } sdram_resp_state_t;

    function automatic logic [7:0] half_be(input logic hi);
        return hi ? 8'hF0 : 8'h0F;
    endfunction

    function automatic logic [SDRAM_DW-1:0] pick_half(input logic [DDRAM_DW-1:0] line,
                                                      input logic hi);
        return hi ? line[63:32] : line[31:0];
    endfunction

endpackage

// File: rtl/sdram_line_cache.sv
// Single-entry read cache holding the most recently fetched 64-bit DDRAM line.
//   clk, reset_n      : clock, asynchronous active-low clear (entry invalid)
//   lookup_tag_i      : line tag to test; hit_o / line_o return match and data
//   fill_i ...        : load a whole line and mark it valid
//   wr_i ...          : write-through of one 32-bit half when the tag matches
module sdram_line_cache
    import sdram_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [TAG_W-1:0]     lookup_tag_i,
    output logic                 hit_o,
    output logic [DDRAM_DW-1:0]  line_o,
    input  logic                 fill_i,
    input  logic [TAG_W-1:0]     fill_tag_i,
    input  logic [DDRAM_DW-1:0]  fill_data_i,
    input  logic                 wr_i,
    input  logic [TAG_W-1:0]     wr_tag_i,
    input  logic                 wr_half_i,
    input  logic [SDRAM_DW-1:0]  wr_data_i
);

    logic [TAG_W-1:0]    tag_q;
    logic [DDRAM_DW-1:0] data_q;
    logic                valid_q;

    assign hit_o  = valid_q && (tag_q == lookup_tag_i);
    assign line_o = data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (fill_i) begin
            tag_q   <= fill_tag_i;
            data_q  <= fill_data_i;
            valid_q <= 1'b1;
        end else if (wr_i && valid_q && (tag_q == wr_tag_i)) begin
            // Keep the cached line coherent with what was just written.
            if (wr_half_i) data_q[63:32] <= wr_data_i;
            else           data_q[31:0]  <= wr_data_i;
        end
    end

endmodule

// File: rtl/sdram_ddram_responder.sv
// Responder for the CPU-side 32-bit four-phase sdram port, mapping every
// request onto one single-beat 64-bit MiSTer DDRAM (Avalon-MM) access.
//   sdram_*      : CPU port (req/write in, ready/done out, 22-bit word address)
//   DDRAM_*      : HPS DDRAM port (RD/WE commands, BUSY = waitrequest)
//   err_timeout  : sticky flag, a read got no DOUT_READY within TIMEOUT cycles
// Each access latches address/data on leaving IDLE; all DDRAM command and
// address outputs come straight from registers.
module sdram_ddram_responder
    import sdram_pkg::*;
#(
    parameter logic [DDRAM_AW-1:0] DDRAM_BASE = 29'h0600_0000,
    parameter bit                  READ_CACHE = 1'b1,
    parameter int                  TIMEOUT    = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [SDRAM_AW-1:0]  sdram_addr,
    input  logic [SDRAM_DW-1:0]  sdram_data_in,
    output logic [SDRAM_DW-1:0]  sdram_data_out,
    input  logic                 sdram_req,
    input  logic                 sdram_write,
    output logic                 sdram_ready,
    output logic                 sdram_done,
    input  logic                 DDRAM_BUSY,
    output logic [7:0]           DDRAM_BURSTCNT,
    output logic [DDRAM_AW-1:0]  DDRAM_ADDR,
    input  logic [DDRAM_DW-1:0]  DDRAM_DOUT,
    input  logic                 DDRAM_DOUT_READY,
    output logic                 DDRAM_RD,
    output logic [DDRAM_DW-1:0]  DDRAM_DIN,
    output logic [7:0]           DDRAM_BE,
    output logic                 DDRAM_WE,
    output logic                 err_timeout
);

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    sdram_resp_state_t    state_q, state_d;
    logic [SDRAM_AW-1:0]  addr_q, addr_d;
    logic [DDRAM_AW-1:0]  ddram_addr_q, ddram_addr_d;
    logic [DDRAM_DW-1:0]  din_q, din_d;
    logic [7:0]           be_q, be_d;
    logic [SDRAM_DW-1:0]  rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 cache_hit_raw;
    logic                 cache_hit;
    logic [DDRAM_DW-1:0]  cache_line;
    logic                 cache_fill;
    logic                 cache_wr;

    sdram_line_cache u_cache (
        .clk          (clk),
        .reset_n      (reset_n),
        .lookup_tag_i (sdram_addr[SDRAM_AW-1:1]),
        .hit_o        (cache_hit_raw),
        .line_o       (cache_line),
        .fill_i       (cache_fill),
        .fill_tag_i   (addr_q[SDRAM_AW-1:1]),
        .fill_data_i  (DDRAM_DOUT),
        .wr_i         (cache_wr),
        .wr_tag_i     (addr_q[SDRAM_AW-1:1]),
        .wr_half_i    (addr_q[0]),
        .wr_data_i    (din_q[SDRAM_DW-1:0])
    );

    assign cache_hit = READ_CACHE && cache_hit_raw;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        ddram_addr_d = ddram_addr_q;
        din_d        = din_q;
        be_d         = be_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        cache_fill   = 1'b0;
        cache_wr     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (sdram_write || sdram_req) begin
                    addr_d       = sdram_addr;
                    ddram_addr_d = DDRAM_BASE + DDRAM_AW'(sdram_addr[SDRAM_AW-1:1]);
                    din_d        = {2{sdram_data_in}};
                    be_d         = half_be(sdram_addr[0]);
                    if (sdram_write) begin
                        state_d = WR_CMD;
                    end else if (cache_hit) begin
                        // Hit answers straight from the line, no DDRAM traffic.
                        rdata_d = pick_half(cache_line, sdram_addr[0]);
                        state_d = RD_ACK;
                    end else begin
                        state_d = RD_CMD;
                    end
                end
            end
            WR_CMD: begin
                if (!DDRAM_BUSY) begin
                    cache_wr = 1'b1;
                    state_d  = WR_ACK;
                end
            end
            WR_ACK: begin
                if (!sdram_write) state_d = IDLE;
            end
            RD_CMD: begin
                if (!DDRAM_BUSY) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                // Data arriving on the final counted cycle still wins over timeout.
                if (DDRAM_DOUT_READY) begin
                    rdata_d    = pick_half(DDRAM_DOUT, addr_q[0]);
                    cache_fill = READ_CACHE;
                    state_d    = RD_ACK;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = 32'hDEAD_BEEF;
                    err_d   = 1'b1;
                    state_d = RD_ACK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RD_ACK: begin
                if (!sdram_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            ddram_addr_q <= '0;
            din_q        <= '0;
            be_q         <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            ddram_addr_q <= ddram_addr_d;
            din_q        <= din_d;
            be_q         <= be_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign DDRAM_WE       = (state_q == WR_CMD);
    assign DDRAM_RD       = (state_q == RD_CMD);
    assign sdram_done     = (state_q == WR_ACK);
    assign sdram_ready    = (state_q == RD_ACK);
    assign DDRAM_ADDR     = ddram_addr_q;
    assign DDRAM_DIN      = din_q;
    assign DDRAM_BE       = be_q;
    assign DDRAM_BURSTCNT = 8'd1;
    assign sdram_data_out = rdata_q;
    assign err_timeout    = err_q;

endmodule

// File: tb/tb_sdram_ddram_responder.sv
// Bench for sdram_ddram_responder. Transactions are scripted cycle by cycle;
// each script states the outputs the port protocol demands for every cycle,
// a DDRAM memory model supplies read data, and read results are expected to
// equal the memory contents (write-through keeps a cached line coherent).
module tb_sdram_ddram_responder;

    localparam logic [28:0] BASE = 29'h0600_0000;
    localparam int          TMO  = 1024;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [21:0] sdram_addr = '0;
    logic [31:0] sdram_data_in = '0;
    logic [31:0] sdram_data_out;
    logic        sdram_req = 1'b0;
    logic        sdram_write = 1'b0;
    logic        sdram_ready;
    logic        sdram_done;
    logic        DDRAM_BUSY = 1'b0;
    logic [7:0]  DDRAM_BURSTCNT;
    logic [28:0] DDRAM_ADDR;
    logic [63:0] DDRAM_DOUT = '0;
    logic        DDRAM_DOUT_READY = 1'b0;
    logic        DDRAM_RD;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic        DDRAM_WE;
    logic        err_timeout;

    always #5 clk = ~clk;

    sdram_ddram_responder #(
        .DDRAM_BASE (BASE),
        .READ_CACHE (1'b1),
        .TIMEOUT    (TMO)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .sdram_addr       (sdram_addr),
        .sdram_data_in    (sdram_data_in),
        .sdram_data_out   (sdram_data_out),
        .sdram_req        (sdram_req),
        .sdram_write      (sdram_write),
        .sdram_ready      (sdram_ready),
        .sdram_done       (sdram_done),
        .DDRAM_BUSY       (DDRAM_BUSY),
        .DDRAM_BURSTCNT   (DDRAM_BURSTCNT),
        .DDRAM_ADDR       (DDRAM_ADDR),
        .DDRAM_DOUT       (DDRAM_DOUT),
        .DDRAM_DOUT_READY (DDRAM_DOUT_READY),
        .DDRAM_RD         (DDRAM_RD),
        .DDRAM_DIN        (DDRAM_DIN),
        .DDRAM_BE         (DDRAM_BE),
        .DDRAM_WE         (DDRAM_WE),
        .err_timeout      (err_timeout)
    );

    // Expected outputs for the current cycle.
    logic        exp_rd, exp_we, exp_ready, exp_done, exp_err;
    logic [28:0] exp_addr;
    logic [63:0] exp_din;
    logic [7:0]  exp_be;
    logic [31:0] exp_data;
    bit          rst_known;   // registers still hold reset values

    // Memory model and cache-residency model.
    logic [63:0] mem [int];
    int          last_line;

    // Observations for the directed literal checks.
    int          rd_cnt, we_cnt;
    logic [28:0] we_addr;
    logic [63:0] we_din;
    logic [7:0]  we_be;
    logic [31:0] ack_data;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("rd",       64'(DDRAM_RD),       64'(exp_rd));
        chk("we",       64'(DDRAM_WE),       64'(exp_we));
        chk("ready",    64'(sdram_ready),    64'(exp_ready));
        chk("done",     64'(sdram_done),     64'(exp_done));
        chk("err",      64'(err_timeout),    64'(exp_err));
        chk("burstcnt", 64'(DDRAM_BURSTCNT), 64'd1);
        if (exp_ready || rst_known) chk("data_out", 64'(sdram_data_out), 64'(exp_data));
        if (exp_we || exp_rd || rst_known) chk("addr", 64'(DDRAM_ADDR), 64'(exp_addr));
        if (exp_we || rst_known) begin
            chk("din", DDRAM_DIN, exp_din);
            chk("be",  64'(DDRAM_BE), 64'(exp_be));
        end
        if (DDRAM_RD) rd_cnt++;
        if (DDRAM_WE) begin
            we_cnt++;
            we_addr = DDRAM_ADDR;
            we_din  = DDRAM_DIN;
            we_be   = DDRAM_BE;
        end
        if (sdram_ready) ack_data = sdram_data_out;
    endtask

    // Check the cycle in progress, then move to just after the next edge.
    task automatic step();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] get_line(input int idx);
        if (!mem.exists(idx)) mem[idx] = {$urandom, $urandom};
        return mem[idx];
    endfunction

    task automatic latch(input logic [21:0] a, input logic [31:0] d);
        exp_addr  = BASE + 29'(a[21:1]);
        exp_din   = {d, d};
        exp_be    = a[0] ? 8'hF0 : 8'h0F;
        rst_known = 1'b0;
    endtask

    task automatic wr(input logic [21:0] a, input logic [31:0] d,
                      input int stall, input int hold, input bit early);
        int          idx;
        logic [63:0] ln;
        idx = int'(a[21:1]);
        sdram_write   = 1'b1;
        sdram_addr    = a;
        sdram_data_in = d;
        DDRAM_BUSY    = 1'($urandom);
        step();
        latch(a, d);
        exp_we = 1'b1;
        if (early) sdram_write = 1'b0;
        sdram_addr    = 22'($urandom);
        sdram_data_in = $urandom;
        for (int i = 0; i < stall; i++) begin
            DDRAM_BUSY = 1'b1;
            step();
        end
        DDRAM_BUSY = 1'b0;
        step();
        exp_we   = 1'b0;
        exp_done = 1'b1;
        ln = get_line(idx);
        if (a[0]) ln[63:32] = d;
        else      ln[31:0]  = d;
        mem[idx] = ln;
        if (!early) for (int i = 0; i < hold; i++) step();
        sdram_write = 1'b0;
        step();
        exp_done = 1'b0;
    endtask

    task automatic rd(input logic [21:0] a, input int stall, input int lat,
                      input int hold, input bit early, input bit tmo);
        int          idx;
        logic [63:0] ln;
        logic [31:0] d;
        bit          hit;
        idx = int'(a[21:1]);
        ln  = get_line(idx);
        hit = (last_line == idx);
        d   = $urandom;
        sdram_req     = 1'b1;
        sdram_addr    = a;
        sdram_data_in = d;
        step();
        latch(a, d);
        sdram_addr    = 22'($urandom);
        sdram_data_in = $urandom;
        if (!hit) begin
            exp_rd = 1'b1;
            if (early) sdram_req = 1'b0;
            for (int i = 0; i < stall; i++) begin
                DDRAM_BUSY       = 1'b1;
                DDRAM_DOUT_READY = 1'($urandom);
                DDRAM_DOUT       = {$urandom, $urandom};
                step();
            end
            DDRAM_BUSY       = 1'b0;
            DDRAM_DOUT_READY = 1'b0;
            step();
            exp_rd = 1'b0;
            if (tmo) begin
                for (int i = 0; i < TMO; i++) begin
                    DDRAM_DOUT = {$urandom, $urandom};
                    step();
                end
                exp_err  = 1'b1;
                exp_data = 32'hDEAD_BEEF;
            end else begin
                for (int i = 0; i < lat; i++) begin
                    DDRAM_DOUT = {$urandom, $urandom};
                    step();
                end
                DDRAM_DOUT_READY = 1'b1;
                DDRAM_DOUT       = ln;
                step();
                DDRAM_DOUT_READY = 1'b0;
                exp_data  = a[0] ? ln[63:32] : ln[31:0];
                last_line = idx;
            end
        end else begin
            exp_data = a[0] ? ln[63:32] : ln[31:0];
        end
        exp_ready = 1'b1;
        if (!early || hit) for (int i = 0; i < hold; i++) step();
        sdram_req = 1'b0;
        step();
        exp_ready = 1'b0;
    endtask

    task automatic clear_model();
        exp_rd = 0; exp_we = 0; exp_ready = 0; exp_done = 0; exp_err = 0;
        exp_addr = '0; exp_din = '0; exp_be = '0; exp_data = '0;
        rst_known = 1'b1;
        last_line = -1;
    endtask

    initial begin
        int snap;
        int op;
        logic [21:0] a;
        clear_model();
        rd_cnt = 0; we_cnt = 0; we_addr = '0; we_din = '0; we_be = '0; ack_data = '0;

        for (int i = 0; i < 3; i++) step();
        reset_n = 1'b1;
        step();

        // Write word 1: high half of line 0.
        snap = we_cnt;
        wr(22'd1, 32'o10101111, 0, 2, 1'b0);
        chk("lit_we_cycles", 64'(we_cnt - snap), 64'd1);
        chk("lit_we_addr",   64'(we_addr), 64'h0600_0000);
        chk("lit_we_be",     64'(we_be),   64'hF0);
        chk("lit_we_din",    we_din,       64'h0020_8249_0020_8249);

        // The DDRAM line now holds other content; read word 1 after a stall.
        mem[0] = 64'h0208_1249_0000_0000;
        snap = rd_cnt;
        rd(22'd1, 3, 2, 1, 1'b0, 1'b0);
        chk("lit_rd_cycles", 64'(rd_cnt - snap), 64'd4);
        chk("lit_rd_data",   64'(ack_data), 64'h0208_1249);

        // Word 0 shares the line: cache hit, no DDRAM read.
        snap = rd_cnt;
        rd(22'd0, 0, 0, 0, 1'b0, 1'b0);
        chk("lit_hit_rd_cycles", 64'(rd_cnt - snap), 64'd0);
        chk("lit_hit_data",      64'(ack_data), 64'd0);

        // req and write together: write goes first, then the read.
        sdram_req = 1'b1;
        wr(22'd4, 32'hCAFE_F00D, 1, 0, 1'b0);
        rd(22'd4, 0, 1, 0, 1'b0, 1'b0);
        chk("lit_both_data", 64'(ack_data), 64'hCAFE_F00D);

        // Read with no data return: timeout path.
        rd(22'd10, 0, 0, 1, 1'b0, 1'b1);
        chk("lit_tmo_data", 64'(ack_data), 64'hDEAD_BEEF);
        chk("lit_tmo_err",  64'(err_timeout), 64'd1);
        snap = rd_cnt;
        rd(22'd10, 0, 3, 0, 1'b0, 1'b0);
        chk("lit_after_tmo_rd_cycles", 64'(rd_cnt - snap), 64'd1);

        // Reset in RD_WAIT, then a late DOUT_READY must be ignored.
        sdram_req  = 1'b1;
        sdram_addr = 22'd20;
        step();
        latch(22'd20, sdram_data_in);
        exp_rd = 1'b1;
        DDRAM_BUSY = 1'b0;
        step();
        exp_rd = 1'b0;
        step();
        reset_n   = 1'b0;
        sdram_req = 1'b0;
        clear_model();
        step();
        step();
        reset_n = 1'b1;
        step();
        DDRAM_DOUT_READY = 1'b1;
        DDRAM_DOUT       = get_line(10);
        step();
        DDRAM_DOUT_READY = 1'b0;
        step();
        snap = rd_cnt;
        rd(22'd20, 0, 0, 0, 1'b0, 1'b0);
        chk("lit_post_reset_miss", 64'(rd_cnt - snap), 64'd1);

        // Randomised traffic over a small address pool.
        for (int n = 0; n < 200; n++) begin
            op = int'($urandom_range(0, 5));
            a  = ($urandom_range(0, 3) == 0) ? 22'h3FFFF0 + 22'($urandom_range(0, 3))
                                            : 22'($urandom_range(0, 11));
            if (op <= 1) begin
                wr(a, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                   ($urandom_range(0, 3) == 0));
            end else if (op == 5) begin
                sdram_req = 1'b1;
                wr(a, $urandom, int'($urandom_range(0, 2)), 0, 1'b0);
                rd(a, int'($urandom_range(0, 2)), int'($urandom_range(0, 4)), 0, 1'b0, 1'b0);
            end else begin
                rd(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                   int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0), 1'b0);
            end
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
        end

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
